fp32_mul_dispatch: RTL and testbench
====================================

# fp32_mul_dispatch

Upstream feeder for `multiplier_fp32`. It accepts operand pairs on a valid/ready interface and buffers them in a DEPTH-entry FIFO. It issues one pair at a time to the multiplier with the `rd`/`wr` handshake, captures `z`, and presents results in order on a valid/ready output. A watchdog replaces a result that never arrives with a quiet NaN and raises a sticky error.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, at least 2.
- `TIMEOUT`, 64: cycles allowed in WAIT before a timeout fires; at least 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: FIFO can accept; equals `count < DEPTH`.
- `in_x`, `in_y` in 32: fp32 operands.
- `mul_rd` out 1: start pulse to `multiplier_fp32.rd`.
- `mul_x`, `mul_y` out 32: operands to the multiplier.
- `mul_wr` in 1: result-ready from `multiplier_fp32.wr`.
- `mul_z` in 32: product from `multiplier_fp32.z`.
- `out_valid` out 1: result register holds data.
- `out_ready` in 1: consumer accepts the result.
- `out_z` out 32: fp32 product.
- `timeout_err` out 1: sticky; set by any timeout.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO push happens when `in_valid && in_ready`. Pop happens on completion only, so the head stays stable while in flight. Simultaneous push and pop leave `count` unchanged. Read and write pointers wrap modulo DEPTH. There is no combinational pass-through: `in_ready` depends only on the registered `count`.
- `mul_x`/`mul_y` are registered. They load the FIFO head on the IDLE→ISSUE edge and hold until the next issue.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when `count != 0` and `out_valid == 0` (or `out_valid && out_ready` that same cycle). Otherwise stay in IDLE.
  - ISSUE: `mul_rd` = 1 for exactly this one cycle. Always → WAIT.
  - WAIT: `wr_q` is `mul_wr` registered. A rise means `mul_wr && !wr_q`.
    - On a rise: `out_z` ← `mul_z`, `out_valid` ← 1, pop, → IDLE.
    - If there is no rise and `wait_cnt == TIMEOUT-1`: `out_z` ← 32'h7FC00000, `out_valid` ← 1, `timeout_err` ← 1, pop, → IDLE.
    - Otherwise `wait_cnt` increments. It clears on entry to WAIT.
- `mul_wr` is only edge-detected in WAIT. If it is already high and remains high from a previous operation, it is not treated as a completion.
- `out_valid` clears on `out_valid && out_ready` unless a new capture occurs on the same edge. The issue condition makes that overlap impossible, so a capture never overwrites an unconsumed result.
- Results leave in FIFO (arrival) order. At most one operation is in flight.
- `timeout_err` clears only on reset.

## Timing
- Reset values (while `reset` = 0, applied asynchronously):
  - FIFO empty, `count` = 0, `in_ready` = 1.
  - `mul_rd` = 0, `mul_x` = `mul_y` = 0.
  - `out_valid` = 0, `out_z` = 0, `timeout_err` = 0.
  - State IDLE, `wait_cnt` = 0, `wr_q` = 0.
- Reset mid-operation drops the in-flight operation and all FIFO contents. No output is produced for them.
- Cycle sequence for one pair, with the FIFO and output empty:
  - Edge E0: accept the pair.
  - Edge E1: → ISSUE. `mul_rd` is high from E1 to E2.
  - Edge E2: → WAIT.
  - If `mul_wr` rises before edge E2+k, then at E2+k `out_valid` = 1.
  - Minimum accept-to-`out_valid` latency is 3 edges.
- Back-to-back throughput: one result per (multiplier latency + 3) cycles while `out_ready` = 1.
- Full boundary: with `count` = DEPTH, `in_ready` = 0. It returns to 1 the cycle after a completion pops.

## Test plan
- **Single op.** After reset, push 0x42F60000 × 0x42F60000 (123 × 123) into a behavioural multiplier model with latency 5.
  - `mul_rd` is high for exactly 1 cycle, 1 edge after the accept.
  - `out_z` = 0x466C6400.
  - `out_valid` rises 8 edges after the accept.
- **Burst.** Hold `out_ready` = 1 and push 6 pairs back-to-back with DEPTH = 4.
  - `in_ready` drops after 4 accepts.
  - Results appear in order: -43 × 43 = 0xC4E72000, 1 × 10 = 0x41200000, Inf × 0 = 0x7FC00000, and so on.
  - `count` never exceeds 4.
- **Backpressure.** Hold `out_ready` = 0 with 2 pairs queued.
  - The first result is held stable.
  - No second `mul_rd` occurs until `out_ready` is pulsed.
  - The second result follows correctly.
- **Timeout.** The model never raises `mul_wr`; TIMEOUT = 8.
  - `out_z` = 0x7FC00000 after 8 cycles in WAIT.
  - `timeout_err` = 1 and stays set.
  - The next op, 1 × 10, still returns 0x41200000.
- **Stuck `wr`.** The model leaves `mul_wr` high between ops.
  - The second op completes only after `mul_wr` falls and rises again; it does not complete in its first WAIT cycle.
- **Reset mid-op.** Assert `reset` = 0 in WAIT with 3 pairs queued.
  - All outputs return to their reset values immediately.
  - After release, no stale result appears, and a new push produces the correct result.

Source files
------------

// File: rtl/fp32_mul_dispatch.sv
// rtl/fp32_mul_dispatch.sv - operand FIFO and single-issue sequencer feeding multiplier_fp32
// Results are captured on a rising mul_wr (or a watchdog NaN) and presented in arrival order.
module fp32_mul_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_x,
    input  logic [31:0]              in_y,
    output logic                     mul_rd,
    output logic [31:0]              mul_x,
    output logic [31:0]              mul_y,
    input  logic                     mul_wr,
    input  logic [31:0]              mul_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_z,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state;
    logic [31:0]     mem_x [DEPTH];
    logic [31:0]     mem_y [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TW-1:0]   wait_cnt;
    logic            wr_q;

    logic            push;
    logic            pop;
    logic            issue;
    logic            rise;
    logic            cap_ok;
    logic            cap_to;

    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready;
    // A new issue is allowed only when the result register is free or being drained this cycle.
    assign issue    = (state == S_IDLE) && (count != '0) && (!out_valid || out_ready);
    assign rise     = mul_wr && !wr_q;
    assign cap_ok   = (state == S_WAIT) && rise;
    assign cap_to   = (state == S_WAIT) && !rise && (wait_cnt == WAIT_LAST);
    assign pop      = cap_ok || cap_to;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            mul_rd      <= 1'b0;
            mul_x       <= '0;
            mul_y       <= '0;
            wait_cnt    <= '0;
            wr_q        <= 1'b0;
            out_valid   <= 1'b0;
            out_z       <= '0;
            timeout_err <= 1'b0;
        end else begin
            wr_q <= mul_wr;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state  <= S_ISSUE;
                        mul_rd <= 1'b1;
                        mul_x  <= mem_x[rd_ptr];
                        mul_y  <= mem_y[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    mul_rd   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (cap_ok) begin
                        out_z     <= mul_z;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end else if (cap_to) begin
                        out_z       <= QNAN;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    mul_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_mul_dispatch.sv
// tb/tb_fp32_mul_dispatch.sv - self-checking bench for fp32_mul_dispatch
// Drives directed and random operand pairs against a behavioural multiplier and a result scoreboard.
module tb_fp32_mul_dispatch;

    localparam int DEPTH    = 4;
    localparam int TIMEOUT  = 8;
    localparam int LAT      = 5;
    localparam int M_NORMAL = 0;
    localparam int M_NEVER  = 1;
    localparam int M_STUCK  = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        mul_rd;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic        mul_wr;
    logic [31:0] mul_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        timeout_err;
    logic [2:0]  count;

    fp32_mul_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .mul_rd      (mul_rd),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_wr      (mul_wr),
        .mul_z       (mul_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .timeout_err (timeout_err),
        .count       (count)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          mode = M_NORMAL;
    int          rd_count = 0;
    int          rd_edge = 0;
    int          ov_edge = 0;
    int          max_cnt = 0;
    int          acc_edge = 0;
    logic        rd_prev = 1'b0;
    logic        ov_prev = 1'b0;
    logic [31:0] exp_q[$];

    logic        m_busy;
    int          m_cnt;
    logic [31:0] m_x;
    logic [31:0] m_y;

    // Stand-in for the multiplier: real products for the named pairs, a fixed scramble otherwise.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h42F6_0000 && y == 32'h42F6_0000) return 32'h466C_6400;
        if (x == 32'hC22C_0000 && y == 32'h422C_0000) return 32'hC4E7_2000;
        if (x == 32'h3F80_0000 && y == 32'h4120_0000) return 32'h4120_0000;
        if (x == 32'h7F80_0000 && y == 32'h0000_0000) return 32'h7FC0_0000;
        return x ^ {y[15:0], y[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        check("push_accept", {31'b0, in_ready}, 32'd1);
        tick();
        acc_edge = cyc;
        exp_q.push_back(z);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 300) begin
            tick();
            g++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        check(tag, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_x    <= '0;
            m_y    <= '0;
            mul_wr <= 1'b0;
            mul_z  <= '0;
        end else if (mul_rd) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_x    <= mul_x;
            m_y    <= mul_y;
            if (mode != M_STUCK) mul_wr <= 1'b0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 1 && mode == M_STUCK) mul_wr <= 1'b0;
            if (m_cnt == LAT) begin
                m_busy <= 1'b0;
                if (mode != M_NEVER) begin
                    mul_wr <= 1'b1;
                    mul_z  <= ref_mul(m_x, m_y);
                end
            end
        end else if (mode == M_NORMAL) begin
            mul_wr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (mul_rd) begin
                rd_count++;
                if (!rd_prev) rd_edge = cyc;
            end
            if (out_valid && !ov_prev) ov_edge = cyc;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $error("FAIL stale_result: observed %h expected no result", out_z);
                end else begin
                    check("result", out_z, exp_q.pop_front());
                end
            end
        end
        rd_prev = mul_rd;
        ov_prev = out_valid;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] bx[6];
        logic [31:0] by[6];
        logic [31:0] rx;
        logic [31:0] ry;
        int          a;
        int          rd_base;

        reset = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mul_rd", {31'b0, mul_rd}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_z", out_z, 32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        reset = 1'b1;
        tick();

        rd_base = rd_count;
        push(32'h42F6_0000, 32'h42F6_0000, 32'h466C_6400);
        a = acc_edge;
        wait_drain();
        check("single_rd_edge", 32'(rd_edge), 32'(a + 1));
        check("single_rd_width", 32'(rd_count - rd_base), 32'd1);
        check("single_latency", 32'(ov_edge), 32'(a + 8));
        check("single_out_z", out_z, 32'h466C_6400);

        bx[0] = 32'hC22C_0000; by[0] = 32'h422C_0000;
        bx[1] = 32'h3F80_0000; by[1] = 32'h4120_0000;
        bx[2] = 32'h7F80_0000; by[2] = 32'h0000_0000;
        for (int i = 3; i < 6; i++) begin
            bx[i] = $urandom;
            by[i] = $urandom;
        end
        max_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            push(bx[i], by[i], ref_mul(bx[i], by[i]));
            if (i < 4) begin
                check("burst_count", 32'(count), 32'(i + 1));
                check("burst_in_ready", {31'b0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
            end
        end
        wait_drain();
        check("burst_max_count", 32'(max_cnt), 32'd4);

        out_ready = 1'b0;
        rd_base = rd_count;
        rx = $urandom; ry = $urandom;
        push(rx, ry, ref_mul(rx, ry));
        rx = $urandom; ry = $urandom;
        push(rx, ry, ref_mul(rx, ry));
        wait_valid("bp_first_valid");
        repeat (15) tick();
        check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        check("bp_hold_z", out_z, exp_q[0]);
        check("bp_no_issue", 32'(rd_count - rd_base), 32'd1);
        check("bp_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("bp_second_valid");
        check("bp_second_issue", 32'(rd_count - rd_base), 32'd2);
        check("bp_second_z", out_z, exp_q[0]);
        out_ready = 1'b1;
        wait_drain();

        mode = M_NEVER;
        rx = $urandom; ry = $urandom;
        push(rx, ry, 32'h7FC0_0000);
        a = acc_edge;
        wait_drain();
        check("to_latency", 32'(ov_edge), 32'(a + 2 + TIMEOUT));
        check("to_out_z", out_z, 32'h7FC0_0000);
        check("to_err_set", {31'b0, timeout_err}, 32'd1);
        mode = M_NORMAL;
        push(32'h3F80_0000, 32'h4120_0000, 32'h4120_0000);
        wait_drain();
        check("to_next_z", out_z, 32'h4120_0000);
        check("to_err_sticky", {31'b0, timeout_err}, 32'd1);

        mode = M_STUCK;
        rx = $urandom; ry = $urandom;
        push(rx, ry, ref_mul(rx, ry));
        wait_drain();
        rx = $urandom; ry = $urandom;
        push(rx, ry, ref_mul(rx, ry));
        a = acc_edge;
        wait_drain();
        check("stuck_latency", 32'(ov_edge), 32'(a + 8));
        check("stuck_out_z", out_z, ref_mul(rx, ry));

        mode = M_NORMAL;
        for (int i = 0; i < 3; i++) begin
            rx = $urandom; ry = $urandom;
            push(rx, ry, ref_mul(rx, ry));
        end
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_mul_rd", {31'b0, mul_rd}, 32'd0);
        check("mid_rst_mul_x", mul_x, 32'd0);
        check("mid_rst_mul_y", mul_y, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_z", out_z, 32'd0);
        check("mid_rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (20) tick();
        check("post_rst_no_output", {31'b0, out_valid}, 32'd0);
        check("post_rst_count", 32'(count), 32'd0);
        rx = $urandom; ry = $urandom;
        push(rx, ry, ref_mul(rx, ry));
        wait_drain();
        check("post_rst_out_z", out_z, ref_mul(rx, ry));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
